// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks: word width, arbiter FSM states
// and the owner-index width helper.
package fifo_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index width for an N-entry vector; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Round-robin winner search from start_i upward with wrap; purely combinational,
// zero latency, no backpressure (caller decides when the result is used).
module rr_arb_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] winner_o
);

    logic [IDX_W:0] cand;

    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, start_i} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!found_o && req_i[cand[IDX_W-1:0]]) begin
                found_o  = 1'b1;
                winner_o = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port; first write one cycle after a request
// is seen in IDLE, bursts of up to MAX_BURST words; fifo_full stalls the grant in place.
module fifo_rr_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = fifo_pkg::DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ack,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_d_in,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy
);

    import fifo_pkg::*;

    localparam int IDX_W  = idx_width(N_REQ);
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_owner_q, last_owner_d;
    logic [BCNT_W-1:0] beat_q, beat_d;

    logic              owner_req;
    logic              xfer;
    logic              release_grant;
    logic [IDX_W-1:0]  pick_base;
    logic [IDX_W-1:0]  pick_start;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_winner;

    assign owner_req = req[owner_q];

    // Gating with rst keeps a pending word unwritten while reset is being applied.
    assign xfer = rst && (state_q == GRANT) && owner_req && !fifo_full;

    assign release_grant = (state_q == GRANT) &&
                           (!owner_req || (xfer && (beat_q == LAST_BEAT)));

    // On release the outgoing owner becomes last_owner, so both paths search from base+1.
    assign pick_base  = (state_q == GRANT) ? owner_q : last_owner_q;
    assign pick_start = (pick_base == LAST_IDX) ? '0 : pick_base + IDX_W'(1);

    rr_arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i    (req),
        .start_i  (pick_start),
        .found_o  (pick_found),
        .winner_o (pick_winner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_d       = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    owner_d = pick_winner;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    last_owner_d = owner_q;
                    beat_d       = '0;
                    if (pick_found) begin
                        owner_d = pick_winner;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    beat_d = beat_q + BCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
        end
    end

    always_comb begin
        fifo_d_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                fifo_d_in = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign fifo_wr_en = xfer;
    assign req_ack    = xfer ? (N_REQ'(1) << owner_q) : '0;
    assign owner      = owner_q;
    assign busy       = (state_q == GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            assert ($onehot0(req_ack));
            assert (beat_q <= LAST_BEAT);
        end
    end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Bench for fifo_rr_wr_arbiter: producer streams drive req/req_data, a scoreboard queue
// holds the expected FIFO write order and is popped on every fifo_wr_en.
module tb_fifo_rr_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic           fifo_full;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_d_in;
    logic [1:0]     owner;
    logic           busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] words [N][16];
    int         len [N];
    int         pos [N];
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    logic [N-1:0] last_ack;

    bit         wr_log [$];
    bit         busy_log [$];
    logic [1:0] own_log [$];
    int         widx [$];
    int         wr_cnt;
    bit         ok;

    fifo_rr_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_d_in  (fifo_d_in),
        .owner      (owner),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard side: every write must match the head of exp_q.
    always @(negedge clk) begin
        last_ack = req_ack;
        wr_log.push_back(fifo_wr_en === 1'b1);
        busy_log.push_back(busy === 1'b1);
        own_log.push_back(owner);
        if (fifo_wr_en === 1'b1) begin
            wr_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_write: got %02h, required no write", fifo_d_in);
            end else begin
                mon_exp = exp_q.pop_front();
                if (fifo_d_in !== mon_exp) begin
                    miscompares++;
                    $display("FAIL sb_data: got %02h, required %02h", fifo_d_in, mon_exp);
                end
            end
            vectors++;
            if (req_ack !== (N'(1) << owner)) begin
                miscompares++;
                $display("FAIL ack_onehot: got %b, required %b", req_ack, N'(1) << owner);
            end
        end else begin
            vectors++;
            if (req_ack !== '0) begin
                miscompares++;
                $display("FAIL ack_without_write: got %b, required 0000", req_ack);
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pos[i] < len[i]) begin
                req[i] = 1'b1;
                req_data[i*W +: W] = words[i][pos[i]];
            end else begin
                req[i] = 1'b0;
                req_data[i*W +: W] = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (last_ack[i] === 1'b1) pos[i]++;
        end
        drive();
    endtask

    task automatic set_stream(input int p, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) words[p][k] = base + 8'(k);
        len[p] = n;
        pos[p] = 0;
        drive();
    endtask

    task automatic clear_logs();
        wr_log.delete();
        busy_log.delete();
        own_log.delete();
        wr_cnt = 0;
    endtask

    task automatic collect_writes();
        widx.delete();
        for (int k = 0; k < wr_log.size(); k++) begin
            if (wr_log[k]) widx.push_back(k);
        end
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) begin
            if (pos[i] < len[i]) return 1'b0;
        end
        return exp_q.size() == 0;
    endfunction

    task automatic drain(input int budget, output bit done);
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            tick();
            if (all_done()) done = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            len[i] = 0;
            pos[i] = 0;
        end
        exp_q.delete();
        drive();
        tick();
        tick();
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fifo_full = 1'b0;
        set_stream(0, 8'h11, 3);
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_busy: got %b, required 0", busy);
            end
            vectors++;
            if (fifo_wr_en !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_wr_en: got %b, required 0", fifo_wr_en);
            end
            vectors++;
            if (req_ack !== '0) begin
                miscompares++;
                $display("FAIL reset_ack: got %b, required 0000", req_ack);
            end
        end
        #1;
        rst = 1'b1;
        clear_logs();
        for (int k = 0; k < 3; k++) exp_q.push_back(8'h11 + 8'(k));
        drain(20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_timeout: got %0d words left, required 0", exp_q.size());
        end
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (wr_log[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL single_wr_cycle%0d: got %b, required 1", k, wr_log[k]);
            end
        end
        vectors++;
        if (wr_log[3] !== 1'b0 || busy_log[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_release_cycle: got wr=%b busy=%b, required wr=0 busy=1",
                     wr_log[3], busy_log[3]);
        end
        vectors++;
        if (busy_log[4] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_back_to_idle: got busy=%b, required 0", busy_log[4]);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int i = 0; i < N; i++) set_stream(i, 8'(i * 16), 8);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                for (int b = 0; b < MB; b++)
                    exp_q.push_back(8'(i * 16 + r * MB + b));
        drain(300, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rotation_timeout: got %0d words left, required 0", exp_q.size());
        end
        repeat (3) tick();
        collect_writes();
        vectors++;
        if (widx.size() != 32) begin
            miscompares++;
            $display("FAIL rotation_count: got %0d writes, required 32", widx.size());
        end else begin
            vectors++;
            if (widx[31] - widx[0] != 31) begin
                miscompares++;
                $display("FAIL rotation_gaps: got span %0d, required 31", widx[31] - widx[0]);
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        set_stream(2, 8'h20, 6);
        set_stream(3, 8'h30, 2);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h20 + 8'(k));
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h24);
        exp_q.push_back(8'h25);
        for (int k = 0; k < 20 && wr_cnt < 1; k++) tick();
        vectors++;
        if (wr_cnt != 1) begin
            miscompares++;
            $display("FAIL stall_setup: got %0d writes, required 1", wr_cnt);
        end
        fifo_full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            vectors++;
            if (fifo_wr_en !== 1'b0 || req_ack !== '0) begin
                miscompares++;
                $display("FAIL stall_no_write: got wr=%b ack=%b, required wr=0 ack=0000",
                         fifo_wr_en, req_ack);
            end
            vectors++;
            if (owner !== 2'd2 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold: got owner=%0d busy=%b, required owner=2 busy=1",
                         owner, busy);
            end
            tick();
        end
        fifo_full = 1'b0;
        drain(100, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stall_timeout: got %0d words left, required 0", exp_q.size());
        end
    endtask

    task automatic test_early_release();
        do_reset();
        set_stream(1, 8'h1A, 2);
        set_stream(3, 8'h3A, 3);
        exp_q.push_back(8'h1A);
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h3A);
        exp_q.push_back(8'h3B);
        exp_q.push_back(8'h3C);
        drain(60, ok);
        repeat (3) tick();
        collect_writes();
        vectors++;
        if (!ok || widx.size() != 5) begin
            miscompares++;
            $display("FAIL early_count: got %0d writes, required 5", widx.size());
        end else begin
            vectors++;
            if (widx[2] - widx[1] != 2) begin
                miscompares++;
                $display("FAIL early_handover: got gap %0d, required 2", widx[2] - widx[1]);
            end
            vectors++;
            if (own_log[widx[2]] !== 2'd3) begin
                miscompares++;
                $display("FAIL early_new_owner: got %0d, required 3", own_log[widx[2]]);
            end
            for (int k = widx[0]; k <= widx[4]; k++) begin
                vectors++;
                if (busy_log[k] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL early_idle_bubble: got busy=0 at log %0d, required 1", k);
                end
            end
        end
    endtask

    task automatic test_lone_requester();
        int bad_owner;
        do_reset();
        set_stream(2, 8'h60, 10);
        for (int k = 0; k < 10; k++) exp_q.push_back(8'h60 + 8'(k));
        drain(80, ok);
        repeat (3) tick();
        collect_writes();
        vectors++;
        if (!ok || widx.size() != 10) begin
            miscompares++;
            $display("FAIL lone_count: got %0d writes, required 10", widx.size());
        end else begin
            vectors++;
            if (widx[9] - widx[0] != 9) begin
                miscompares++;
                $display("FAIL lone_gaps: got span %0d, required 9", widx[9] - widx[0]);
            end
            bad_owner = 0;
            for (int k = 0; k < 10; k++) begin
                if (own_log[widx[k]] !== 2'd2) bad_owner++;
            end
            vectors++;
            if (bad_owner != 0) begin
                miscompares++;
                $display("FAIL lone_owner: got %0d writes not from 2, required 0", bad_owner);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_stream(0, 8'h00, 6);
        set_stream(1, 8'h10, 2);
        for (int k = 0; k < 6; k++) exp_q.push_back(8'(k));
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        for (int k = 0; k < 20 && wr_cnt < 2; k++) tick();
        vectors++;
        if (wr_cnt != 2) begin
            miscompares++;
            $display("FAIL midrst_setup: got %0d writes, required 2", wr_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (fifo_wr_en !== 1'b0 || req_ack !== '0) begin
            miscompares++;
            $display("FAIL midrst_abort: got wr=%b ack=%b, required wr=0 ack=0000",
                     fifo_wr_en, req_ack);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || req_ack !== '0) begin
            miscompares++;
            $display("FAIL midrst_idle: got busy=%b ack=%b, required busy=0 ack=0000",
                     busy, req_ack);
        end
        drain(100, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL midrst_timeout: got %0d words left, required 0", exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b0;
        fifo_full = 1'b0;
        req       = '0;
        req_data  = '0;
        last_ack  = '0;
        wr_cnt    = 0;
        for (int i = 0; i < N; i++) begin
            len[i] = 0;
            pos[i] = 0;
        end
        test_reset();
        test_rotation();
        test_full_stall();
        test_early_release();
        test_lone_requester();
        test_reset_mid_burst();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d words pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000, required completion");
        $fatal(1);
    end

endmodule
